// File: rtl/miriscv_fetch_buffer.sv
// Instruction prefetch buffer: issues word fetches over req/gnt/rvalid, queues
// returned words with their PCs, and presents them to the core under valid/ready.
module miriscv_fetch_buffer #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_addr_o,
  input  logic        fetch_ready_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [31:0]   req_pc_q, req_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];

  logic          empty, full, push, pop, issue, credit_ok;
  logic [CW:0]   inflight;
  logic          unused_lsb;

  assign unused_lsb = ^branch_addr_i[1:0];

  // Credit counts buffered words plus every pending response, including ones
  // that will be discarded, so a push can never find the FIFO full.
  assign inflight  = {1'b0, count_q} + {1'b0, outst_q};
  assign credit_ok = (inflight < (CW+1)'(DEPTH)) && (outst_q < CW'(MAX_OUTSTANDING));

  assign instr_req_o  = !rst_i && !branch_i && credit_ok;
  assign instr_addr_o = req_pc_q;
  assign issue        = instr_req_o && instr_gnt_i;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign push  = instr_rvalid_i && (discard_q == '0) && !branch_i;
  assign pop   = !empty && fetch_ready_i && !branch_i;

  assign fetch_valid_o = !empty;
  assign fetch_instr_o = empty ? 32'h0 : instr_mem_q[rd_ptr_q];
  assign fetch_addr_o  = empty ? 32'h0 : pc_mem_q[rd_ptr_q];

  always_comb begin
    req_pc_d  = req_pc_q;
    resp_pc_d = resp_pc_q;
    count_d   = count_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (branch_i) begin
      // Every response still owed by memory belongs to the old stream; the
      // one arriving this cycle is dropped directly.
      req_pc_d  = {branch_addr_i[31:2], 2'b00};
      resp_pc_d = {branch_addr_i[31:2], 2'b00};
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      outst_d   = outst_q - CW'(instr_rvalid_i);
      discard_d = outst_q - CW'(instr_rvalid_i);
    end else begin
      if (issue) req_pc_d = req_pc_q + 32'd4;
      outst_d = outst_q + CW'(issue) - CW'(instr_rvalid_i);
      if (instr_rvalid_i && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_pc_q  <= BOOT_ADDR;
      resp_pc_q <= BOOT_ADDR;
      count_q   <= '0;
      outst_q   <= '0;
      discard_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      req_pc_q  <= req_pc_d;
      resp_pc_q <= resp_pc_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Storage carries data only; validity lives in count/pointers.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      instr_mem_q[wr_ptr_q] <= instr_rdata_i;
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));

endmodule

// File: tb/tb_miriscv_fetch_buffer.sv
// Randomized bench for miriscv_fetch_buffer: a memory model answers requests,
// a stream-level reference model predicts the core-side output sequence.
module tb_miriscv_fetch_buffer;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] BOOT  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_instr_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_ready_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;

  always #5 clk = ~clk;

  miriscv_fetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .BOOT_ADDR(BOOT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .fetch_valid_o(fetch_valid_o), .fetch_instr_o(fetch_instr_o), .fetch_addr_o(fetch_addr_o),
    .fetch_ready_i(fetch_ready_i), .branch_i(branch_i), .branch_addr_i(branch_addr_i)
  );

  typedef struct { logic [31:0] pc; logic stale; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int rdy; } mem_t;

  pend_t pend_q[$];
  exp_t  exp_q[$];
  mem_t  mem_q[$];
  logic [31:0] m_req_pc = BOOT;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic prev_hold = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor + reference model: compare against current model state, then
  // advance the model by what happens at the coming rising edge.
  always @(negedge clk) begin
    logic  exp_req, pop;
    pend_t p;
    exp_req = !rst_i && !branch_i && (exp_q.size() + pend_q.size() < DEPTH)
              && (pend_q.size() < MAXO);
    check("instr_req", instr_req_o, exp_req);
    if (exp_req) check("instr_addr", instr_addr_o, m_req_pc);
    check("fetch_valid", fetch_valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("fetch_addr", fetch_addr_o, exp_q[0].pc);
      check("fetch_instr", fetch_instr_o, exp_q[0].instr);
    end else begin
      check("empty_addr", fetch_addr_o, 32'h0);
      check("empty_instr", fetch_instr_o, 32'h0);
    end
    if (prev_hold && !branch_i && !rst_i) begin
      check("req_stable", instr_req_o, 1'b1);
      check("addr_stable", instr_addr_o, prev_addr);
    end
    prev_hold = instr_req_o && !instr_gnt_i && !rst_i;
    prev_addr = instr_addr_o;

    if (rst_i) begin
      pend_q.delete();
      exp_q.delete();
      mem_q.delete();
      m_req_pc = BOOT;
    end else begin
      if (instr_rvalid_i && mem_q.size() != 0) void'(mem_q.pop_front());
      if (instr_req_o && instr_gnt_i) mem_q.push_back('{instr_addr_o, cyc + 1});
      pop = (exp_q.size() != 0) && fetch_ready_i;
      if (branch_i) begin
        exp_q.delete();
        foreach (pend_q[i]) pend_q[i].stale = 1'b1;
        if (instr_rvalid_i && pend_q.size() != 0) void'(pend_q.pop_front());
        m_req_pc = {branch_addr_i[31:2], 2'b00};
      end else begin
        if (pop) void'(exp_q.pop_front());
        if (instr_rvalid_i && pend_q.size() != 0) begin
          p = pend_q.pop_front();
          if (!p.stale) exp_q.push_back('{p.pc, word(p.pc)});
        end
        if (exp_req && instr_gnt_i) begin
          pend_q.push_back('{m_req_pc, 1'b0});
          m_req_pc = m_req_pc + 32'd4;
        end
      end
    end
  end

  task automatic step(input int prst, input int pr, input int pg, input int pv, input int pb);
    logic [31:0] t;
    @(posedge clk);
    #1;
    cyc++;
    rst_i         = ($urandom_range(0, 999) < prst);
    fetch_ready_i = ($urandom_range(0, 99) < pr);
    branch_i      = !rst_i && ($urandom_range(0, 99) < pb);
    t = $urandom;
    if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
    branch_addr_i = t;
    instr_gnt_i   = ($urandom_range(0, 99) < pg);
    if (!rst_i && mem_q.size() != 0 && mem_q[0].rdy <= cyc && $urandom_range(0, 99) < pv) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = word(mem_q[0].addr);
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = $urandom;
    end
  endtask

  initial begin
    rst_i = 1'b1; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0;
    fetch_ready_i = 1'b0; branch_i = 1'b0; branch_addr_i = 32'h0;
    repeat (3) step(1000, 0, 0, 0, 0);
    repeat (40) step(0, 100, 100, 100, 0);
    repeat (25) step(0, 0, 100, 100, 0);
    repeat (10) step(0, 100, 100, 100, 0);
    repeat (6) step(0, 100, 0, 100, 0);
    repeat (20) step(0, 100, 100, 100, 0);
    repeat (600) step(0, 70, 60, 60, 5);
    repeat (400) step(0, 100, 100, 100, 15);
    repeat (400) step(0, 50, 80, 40, 20);
    repeat (2000) step(10, 60, 70, 60, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
